// File: rtl/mem_req_arbiter.sv
// Round-robin arbiter sharing one fixed-latency memory port between NUM_REQ requesters.
// Define MEM_ARB_LOCK_EN to honour REQ_LOCK (IDLE/LOCKED bus-lock FSM); otherwise pure RR.
module mem_req_arbiter #(
    parameter int unsigned NUM_REQ = 2,
    parameter int unsigned ADDR_W  = 6,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned MEM_LAT = 2
) (
    input  logic                        CLK,
    input  logic                        RESET,
    input  logic [NUM_REQ-1:0]          REQ_VLD,
    output logic [NUM_REQ-1:0]          REQ_RDY,
    input  logic [NUM_REQ-1:0]          REQ_CMD,
    input  logic [NUM_REQ*ADDR_W-1:0]   REQ_ADDR,
    input  logic [NUM_REQ*DATA_W-1:0]   REQ_DATA,
    input  logic [NUM_REQ-1:0]          REQ_LOCK,
    output logic                        MEM_VLD,
    output logic                        MEM_CMD,
    output logic [ADDR_W-1:0]           MEM_ADDR,
    output logic [DATA_W-1:0]           MEM_DATA,
    input  logic                        MEM_RSP_VLD,
    input  logic [DATA_W-1:0]           MEM_RSP_DATA,
    input  logic                        MEM_RSP_STATUS,
    output logic [NUM_REQ-1:0]          RSP_VLD,
    output logic [DATA_W-1:0]           RSP_DATA,
    output logic                        RSP_STATUS,
    output logic                        ERR_UNEXP,
    output logic                        ERR_MISS
);

    localparam int unsigned ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [ID_W-1:0]    ptr_q, ptr_d;
    logic [ID_W-1:0]    rr_idx;
    logic               rr_found;
    logic [NUM_REQ-1:0] acc_vec;
    logic               accept;
    logic [ID_W-1:0]    acc_id;
    logic               sel_cmd;
    logic [ADDR_W-1:0]  sel_addr;
    logic [DATA_W-1:0]  sel_data;
    logic               lock_active;
    logic [ID_W-1:0]    lock_owner;

`ifdef MEM_ARB_LOCK_EN
    typedef enum logic {StIdle, StLocked} lock_state_e;

    lock_state_e     state_q, state_d;
    logic [ID_W-1:0] owner_q, owner_d;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q <= StIdle;
            owner_q <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
        end
    end

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        if (accept) begin
            unique case (state_q)
                StIdle: begin
                    if (REQ_LOCK[acc_id]) begin
                        state_d = StLocked;
                        owner_d = acc_id;
                    end
                end
                StLocked: begin
                    if (!REQ_LOCK[acc_id]) state_d = StIdle;
                end
            endcase
        end
    end

    assign lock_active = (state_q == StLocked);
    assign lock_owner  = owner_q;
`else
    logic unused_lock;

    assign unused_lock = ^REQ_LOCK;
    assign lock_active = 1'b0;
    assign lock_owner  = '0;
`endif

    // Grant: the lock owner alone while locked, else first valid at or after the pointer.
    always_comb begin
        REQ_RDY  = '0;
        rr_found = 1'b0;
        rr_idx   = '0;
        if (!RESET) begin
            if (lock_active) begin
                REQ_RDY[lock_owner] = REQ_VLD[lock_owner];
            end else begin
                for (int unsigned k = 0; k < NUM_REQ; k++) begin
                    rr_idx = ID_W'((32'(ptr_q) + k) % NUM_REQ);
                    if (!rr_found && REQ_VLD[rr_idx]) begin
                        REQ_RDY[rr_idx] = 1'b1;
                        rr_found        = 1'b1;
                    end
                end
            end
        end
    end

    assign acc_vec = REQ_VLD & REQ_RDY;
    assign accept  = |acc_vec;

    always_comb begin
        acc_id   = '0;
        sel_cmd  = 1'b0;
        sel_addr = '0;
        sel_data = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (acc_vec[i]) begin
                acc_id   = ID_W'(i);
                sel_cmd  = REQ_CMD[i];
                sel_addr = REQ_ADDR[i*ADDR_W +: ADDR_W];
                sel_data = REQ_DATA[i*DATA_W +: DATA_W];
            end
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (accept) begin
            ptr_d = (32'(acc_id) == NUM_REQ - 1) ? '0 : acc_id + 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            ptr_q    <= '0;
            MEM_VLD  <= 1'b0;
            MEM_CMD  <= 1'b0;
            MEM_ADDR <= '0;
            MEM_DATA <= '0;
        end else begin
            ptr_q   <= ptr_d;
            MEM_VLD <= accept;
            if (accept) begin
                MEM_CMD  <= sel_cmd;
                MEM_ADDR <= sel_addr;
                MEM_DATA <= sel_data;
            end
        end
    end

    // Stage MEM_LAT lines up with the memory response for the beat issued MEM_LAT+1 ago.
    logic [MEM_LAT:0] tag_vld_q;
    logic [ID_W-1:0]  tag_id_q [MEM_LAT+1];

    always_ff @(posedge CLK) begin
        if (RESET) begin
            tag_vld_q <= '0;
            for (int unsigned i = 0; i <= MEM_LAT; i++) tag_id_q[i] <= '0;
        end else begin
            tag_vld_q   <= {tag_vld_q[MEM_LAT-1:0], accept};
            tag_id_q[0] <= acc_id;
            for (int unsigned i = 1; i <= MEM_LAT; i++) tag_id_q[i] <= tag_id_q[i-1];
        end
    end

    logic            tag_hit;
    logic [ID_W-1:0] rsp_id;
    logic            unexp_now, miss_now;
    logic            err_unexp_q, err_miss_q;

    assign tag_hit = tag_vld_q[MEM_LAT];
    assign rsp_id  = tag_id_q[MEM_LAT];

    always_comb begin
        RSP_VLD = '0;
        if (!RESET && MEM_RSP_VLD && tag_hit) RSP_VLD[rsp_id] = 1'b1;
    end

    assign RSP_DATA   = MEM_RSP_DATA;
    assign RSP_STATUS = MEM_RSP_STATUS;

    assign unexp_now = MEM_RSP_VLD & ~tag_hit;
    assign miss_now  = tag_hit & ~MEM_RSP_VLD;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            err_unexp_q <= 1'b0;
            err_miss_q  <= 1'b0;
        end else begin
            err_unexp_q <= err_unexp_q | unexp_now;
            err_miss_q  <= err_miss_q | miss_now;
        end
    end

    // Flags show in the offending cycle and then stay set until RESET.
    assign ERR_UNEXP = ~RESET & (err_unexp_q | unexp_now);
    assign ERR_MISS  = ~RESET & (err_miss_q | miss_now);

endmodule
